sfu_acc_bank: RTL

SFU_ACC_BANK -- requirements
Module: sfu_acc_bank

---
 rtl/sfu_pkg.sv | 28 ++
 rtl/sfu_lane.sv | 68 ++++++
 rtl/sfu_acc_bank.sv | 95 +++++++++
 3 files changed

// File: rtl/sfu_pkg.sv
// rtl/sfu_pkg.sv - shared mode encodings and fixed-point helpers for the SFU accumulator bank
package sfu_pkg;

  typedef enum logic [1:0] {
    MODE_PASS     = 2'b00,
    MODE_RELU     = 2'b01,
    MODE_ABS      = 2'b10,
    MODE_PASS_ALT = 2'b11
  } sfu_mode_e;

  // Helpers operate on 64-bit signed carriers; w is the live width of the value.
  function automatic logic signed [63:0] sext64(input logic [63:0] raw, input int w);
    logic signed [63:0] t;
    t = raw << (64 - w);
    return t >>> (64 - w);
  endfunction

  function automatic logic signed [63:0] sat64(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sfu_lane.sv
// rtl/sfu_lane.sv - one lane: saturating accumulate, output function and running-max tracker
module sfu_lane
  import sfu_pkg::*;
#(
  parameter int PSUM_BW = 16,
  parameter int ACC_BW  = 20,
  parameter int AW      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               acc,
  input  logic [ACC_BW-1:0]  wr_entry,
  input  logic [PSUM_BW-1:0] psum,
  output logic [ACC_BW-1:0]  wr_data,
  input  sfu_mode_e          mode,
  input  logic [ACC_BW-1:0]  rd_entry,
  output logic [PSUM_BW-1:0] rd_result,
  input  logic               res_valid,
  input  logic [PSUM_BW-1:0] res_data,
  input  logic [AW-1:0]      res_idx,
  input  logic               clr_max,
  output logic [PSUM_BW-1:0] max_val,
  output logic [AW-1:0]      max_idx
);

  localparam logic [PSUM_BW-1:0] MAX_INIT = {1'b1, {(PSUM_BW-1){1'b0}}};

  logic signed [63:0] psum_s;
  logic signed [63:0] wr_s;
  logic signed [63:0] rd_s;
  logic signed [63:0] fn_s;
  logic [PSUM_BW-1:0] base_val;
  logic [AW-1:0]      base_idx;

  always_comb begin
    psum_s  = sext64(64'(psum), PSUM_BW);
    wr_s    = sext64(64'(wr_entry), ACC_BW);
    wr_data = acc ? ACC_BW'(sat64(wr_s + psum_s, ACC_BW)) : ACC_BW'(psum_s);
    rd_s    = sext64(64'(rd_entry), ACC_BW);
    // abs is taken at 64 bits so the most negative entry lands on the output's positive limit
    case (mode)
      MODE_RELU: fn_s = (rd_s < 64'sd0) ? 64'sd0 : rd_s;
      MODE_ABS:  fn_s = (rd_s < 64'sd0) ? -rd_s : rd_s;
      default:   fn_s = rd_s;
    endcase
    rd_result = PSUM_BW'(sat64(fn_s, PSUM_BW));
  end

  // A clear in the same cycle as a result makes the result compete against the cleared value.
  always_comb begin
    base_val = clr_max ? MAX_INIT : max_val;
    base_idx = clr_max ? '0 : max_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_val <= MAX_INIT;
      max_idx <= '0;
    end else if (res_valid && ($signed(res_data) > $signed(base_val))) begin
      max_val <= res_data;
      max_idx <= res_idx;
    end else begin
      max_val <= base_val;
      max_idx <= base_idx;
    end
  end

endmodule

// File: rtl/sfu_acc_bank.sv
// rtl/sfu_acc_bank.sv - flop-based multi-lane psum accumulator bank with post-read function and max tracking
module sfu_acc_bank
  import sfu_pkg::*;
#(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int ACC_BW  = 20,
  parameter int DEPTH   = 16,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid_i,
  input  logic                   acc_i,
  input  logic [AW-1:0]          wr_addr_i,
  input  logic [PSUM_BW*COL-1:0] psum_in,
  input  logic                   rd_i,
  input  logic [AW-1:0]          rd_addr_i,
  input  logic [1:0]             mode_i,
  input  logic                   clr_max_i,
  output logic                   out_valid_o,
  output logic [PSUM_BW*COL-1:0] psum_out,
  output logic [PSUM_BW*COL-1:0] max_o,
  output logic [AW*COL-1:0]      max_idx_o
);

  logic [DEPTH-1:0][COL*ACC_BW-1:0] mem;

  logic                   wr_ok;
  logic                   rd_ok;
  logic                   rd_ok_q;
  logic [AW-1:0]          wr_idx;
  logic [AW-1:0]          rd_idx;
  logic [AW-1:0]          rd_addr_q;
  logic [COL*ACC_BW-1:0]  cur_wr_row;
  logic [COL*ACC_BW-1:0]  cur_rd_row;
  logic [COL*ACC_BW-1:0]  new_row;
  logic [COL*PSUM_BW-1:0] fn_row;
  logic                   track_valid;

  // Out-of-range addresses are steered to entry 0 so the array is never indexed past DEPTH.
  always_comb begin
    wr_ok       = int'(wr_addr_i) < DEPTH;
    rd_ok       = int'(rd_addr_i) < DEPTH;
    wr_idx      = wr_ok ? wr_addr_i : '0;
    rd_idx      = rd_ok ? rd_addr_i : '0;
    cur_wr_row  = mem[wr_idx];
    cur_rd_row  = mem[rd_idx];
    track_valid = out_valid_o & rd_ok_q;
  end

  for (genvar k = 0; k < COL; k++) begin : g_lane
    sfu_lane #(
      .PSUM_BW(PSUM_BW),
      .ACC_BW (ACC_BW),
      .AW     (AW)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .acc      (acc_i),
      .wr_entry (cur_wr_row[k*ACC_BW +: ACC_BW]),
      .psum     (psum_in[k*PSUM_BW +: PSUM_BW]),
      .wr_data  (new_row[k*ACC_BW +: ACC_BW]),
      .mode     (sfu_mode_e'(mode_i)),
      .rd_entry (cur_rd_row[k*ACC_BW +: ACC_BW]),
      .rd_result(fn_row[k*PSUM_BW +: PSUM_BW]),
      .res_valid(track_valid),
      .res_data (psum_out[k*PSUM_BW +: PSUM_BW]),
      .res_idx  (rd_addr_q),
      .clr_max  (clr_max_i),
      .max_val  (max_o[k*PSUM_BW +: PSUM_BW]),
      .max_idx  (max_idx_o[k*AW +: AW])
    );
  end

  // Reads sample the array before this edge's write lands, giving read-before-write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem         <= '0;
      out_valid_o <= 1'b0;
      psum_out    <= '0;
      rd_addr_q   <= '0;
      rd_ok_q     <= 1'b0;
    end else begin
      if (in_valid_i && wr_ok) mem[wr_idx] <= new_row;
      out_valid_o <= rd_i;
      if (rd_i) begin
        psum_out  <= rd_ok ? fn_row : '0;
        rd_addr_q <= rd_addr_i;
        rd_ok_q   <= rd_ok;
      end
    end
  end

endmodule
